// File: rtl/finish_issue_unit_pkg.sv
// Shared definitions for the client-side Finish issue unit: default field
// widths, queue depth, burst length and the Finish message layout.
package finish_issue_unit_pkg;

    localparam int FIN_ID_W       = 2;
    localparam int FIN_XACT_W     = 2;
    localparam int FIN_DEPTH      = 2;
    localparam int FIN_DATA_BEATS = 4;

    // Finish message as seen on the Finish bus (default widths).
    typedef struct packed {
        logic [FIN_ID_W-1:0]   src;
        logic [FIN_ID_W-1:0]   dst;
        logic [FIN_XACT_W-1:0] xact_id;
    } finish_t;

    // Build a Finish from a Grant header: the Finish goes back to the manager,
    // so source and destination swap roles.
    function automatic finish_t make_finish(input logic [FIN_ID_W-1:0]   gnt_src,
                                            input logic [FIN_ID_W-1:0]   gnt_dst,
                                            input logic [FIN_XACT_W-1:0] gnt_xact);
        finish_t f;
        f.src     = gnt_dst;
        f.dst     = gnt_src;
        f.xact_id = gnt_xact;
        return f;
    endfunction

endpackage

// File: rtl/finish_issue_unit_queue.sv
// Register FIFO holding pending Finish messages. The caller never enqueues
// when full nor dequeues when empty; the head entry is driven straight from
// storage so it stays stable while the consumer back-pressures.
module finish_queue
    import finish_issue_unit_pkg::*;
#(
    parameter int DEPTH = FIN_DEPTH,
    parameter int WIDTH = 2 * FIN_ID_W + FIN_XACT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Storage, pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq) begin
                mem_r[wr_ptr_r] <= enq_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));

endmodule

// File: rtl/finish_issue_unit.sv
// Client-side Finish generator. Grants pass through to the client unchanged;
// each acknowledged Grant queues one Finish (src/dst swapped) after its last
// beat. Grants needing a Finish stall while the queue is full.
module finish_issue_unit
    import finish_issue_unit_pkg::*;
#(
    parameter int DEPTH      = FIN_DEPTH,
    parameter int ID_W       = FIN_ID_W,
    parameter int XACT_W     = FIN_XACT_W,
    parameter int DATA_BEATS = FIN_DATA_BEATS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gnt_in_valid,
    output logic              gnt_in_ready,
    input  logic [ID_W-1:0]   gnt_in_header_src,
    input  logic [ID_W-1:0]   gnt_in_header_dst,
    input  logic [XACT_W-1:0] gnt_in_manager_xact_id,
    input  logic              gnt_in_has_data,
    input  logic              gnt_in_requires_ack,
    output logic              gnt_out_valid,
    input  logic              gnt_out_ready,
    output logic [ID_W-1:0]   gnt_out_header_src,
    output logic [ID_W-1:0]   gnt_out_header_dst,
    output logic [XACT_W-1:0] gnt_out_manager_xact_id,
    output logic              gnt_out_has_data,
    output logic              gnt_out_requires_ack,
    output logic              fin_valid,
    input  logic              fin_ready,
    output logic [ID_W-1:0]   fin_header_src,
    output logic [ID_W-1:0]   fin_header_dst,
    output logic [XACT_W-1:0] fin_manager_xact_id
);

    localparam int BEAT_W  = $clog2(DATA_BEATS);
    localparam int ENTRY_W = 2 * ID_W + XACT_W;

    logic [BEAT_W-1:0]  beat_cnt_r;
    logic               is_last_s;
    logic               need_enq_s;
    logic               stall_s;
    logic               gnt_fire_s;
    logic               q_full_s;
    logic               q_empty_s;
    logic               q_deq_s;
    logic [ENTRY_W-1:0] q_head_s;

    // A dataless Grant is its own last beat; a data Grant ends on the final beat count.
    assign is_last_s  = !gnt_in_has_data || (beat_cnt_r == BEAT_W'(DATA_BEATS - 1));
    assign need_enq_s = gnt_in_requires_ack && is_last_s;
    // Depends only on the registered full flag: a same-cycle dequeue never frees space.
    assign stall_s    = need_enq_s && q_full_s;

    assign gnt_in_ready = gnt_out_ready && !stall_s;
    assign gnt_fire_s   = gnt_in_valid && gnt_in_ready;

    assign gnt_out_valid           = gnt_in_valid && !stall_s;
    assign gnt_out_header_src      = gnt_in_header_src;
    assign gnt_out_header_dst      = gnt_in_header_dst;
    assign gnt_out_manager_xact_id = gnt_in_manager_xact_id;
    assign gnt_out_has_data        = gnt_in_has_data;
    assign gnt_out_requires_ack    = gnt_in_requires_ack;

    // Beat counter tracks position inside a data Grant; dataless Grants leave it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt_r <= '0;
        end else if (gnt_fire_s && gnt_in_has_data) begin
            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    assign q_deq_s = fin_valid && fin_ready;

    finish_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .enq       (gnt_fire_s && need_enq_s),
        .enq_data  ({gnt_in_header_dst, gnt_in_header_src, gnt_in_manager_xact_id}),
        .deq       (q_deq_s),
        .head_data (q_head_s),
        .full      (q_full_s),
        .empty     (q_empty_s)
    );

    assign fin_valid           = !q_empty_s;
    assign fin_header_src      = q_head_s[ENTRY_W-1 -: ID_W];
    assign fin_header_dst      = q_head_s[XACT_W +: ID_W];
    assign fin_manager_xact_id = q_head_s[XACT_W-1:0];

endmodule

// File: tb/tb_finish_issue_unit.sv
// Directed self-checking bench for finish_issue_unit.
module tb_finish_issue_unit;
    import finish_issue_unit_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       gnt_in_valid, gnt_in_ready;
    logic [1:0] gnt_in_header_src, gnt_in_header_dst, gnt_in_manager_xact_id;
    logic       gnt_in_has_data, gnt_in_requires_ack;
    logic       gnt_out_valid, gnt_out_ready;
    logic [1:0] gnt_out_header_src, gnt_out_header_dst, gnt_out_manager_xact_id;
    logic       gnt_out_has_data, gnt_out_requires_ack;
    logic       fin_valid, fin_ready;
    logic [1:0] fin_header_src, fin_header_dst, fin_manager_xact_id;

    int n_cmp = 0;
    int n_bad = 0;

    finish_issue_unit dut (
        .clk                     (clk),
        .reset                   (reset),
        .gnt_in_valid            (gnt_in_valid),
        .gnt_in_ready            (gnt_in_ready),
        .gnt_in_header_src       (gnt_in_header_src),
        .gnt_in_header_dst       (gnt_in_header_dst),
        .gnt_in_manager_xact_id  (gnt_in_manager_xact_id),
        .gnt_in_has_data         (gnt_in_has_data),
        .gnt_in_requires_ack     (gnt_in_requires_ack),
        .gnt_out_valid           (gnt_out_valid),
        .gnt_out_ready           (gnt_out_ready),
        .gnt_out_header_src      (gnt_out_header_src),
        .gnt_out_header_dst      (gnt_out_header_dst),
        .gnt_out_manager_xact_id (gnt_out_manager_xact_id),
        .gnt_out_has_data        (gnt_out_has_data),
        .gnt_out_requires_ack    (gnt_out_requires_ack),
        .fin_valid               (fin_valid),
        .fin_ready               (fin_ready),
        .fin_header_src          (fin_header_src),
        .fin_header_dst          (fin_header_dst),
        .fin_manager_xact_id     (fin_manager_xact_id)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] src, input logic [1:0] dst, input logic [1:0] xact,
                         input logic has_data, input logic ack);
        gnt_in_valid           = 1'b1;
        gnt_in_header_src      = src;
        gnt_in_header_dst      = dst;
        gnt_in_manager_xact_id = xact;
        gnt_in_has_data        = has_data;
        gnt_in_requires_ack    = ack;
        #1;
    endtask

    task automatic idle();
        gnt_in_valid        = 1'b0;
        gnt_in_has_data     = 1'b0;
        gnt_in_requires_ack = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; fin_ready = 1'b0; gnt_out_ready = 1'b1;
        drive(2'd1, 2'd2, 2'd3, 1'b0, 1'b1);
        n_cmp++; if (fin_valid !== 1'b0) begin n_bad++; $display("FAIL rst_fin_valid got %0b exp 0", fin_valid); end
        n_cmp++; if ({fin_header_src, fin_header_dst, fin_manager_xact_id} !== 6'd0) begin n_bad++;
            $display("FAIL rst_fin_fields got %0h exp 0", {fin_header_src, fin_header_dst, fin_manager_xact_id}); end
        n_cmp++; if (gnt_out_valid !== 1'b1 || gnt_in_ready !== 1'b1) begin n_bad++;
            $display("FAIL rst_gnt_pass got v=%0b r=%0b exp v=1 r=1", gnt_out_valid, gnt_in_ready); end
        idle();
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_dataless_ack();
        finish_t exp_f;
        exp_f = make_finish(2'd2, 2'd1, 2'd3);
        fin_ready = 1'b0; gnt_out_ready = 1'b1;
        drive(2'd2, 2'd1, 2'd3, 1'b0, 1'b1);
        n_cmp++; if (gnt_out_valid !== 1'b1 || gnt_in_ready !== 1'b1) begin n_bad++;
            $display("FAIL dl_gnt_pass got v=%0b r=%0b exp v=1 r=1", gnt_out_valid, gnt_in_ready); end
        n_cmp++; if ({gnt_out_header_src, gnt_out_header_dst, gnt_out_manager_xact_id} !== {2'd2, 2'd1, 2'd3}) begin n_bad++;
            $display("FAIL dl_gnt_fields got %0h exp %0h", {gnt_out_header_src, gnt_out_header_dst, gnt_out_manager_xact_id}, {2'd2, 2'd1, 2'd3}); end
        n_cmp++; if (fin_valid !== 1'b0) begin n_bad++; $display("FAIL dl_fin_early got %0b exp 0", fin_valid); end
        step();
        idle();
        n_cmp++; if (fin_valid !== 1'b1) begin n_bad++; $display("FAIL dl_fin_valid got %0b exp 1", fin_valid); end
        n_cmp++; if ({fin_header_src, fin_header_dst, fin_manager_xact_id} !== exp_f) begin n_bad++;
            $display("FAIL dl_fin_fields got %0h exp %0h", {fin_header_src, fin_header_dst, fin_manager_xact_id}, exp_f); end
        fin_ready = 1'b1;
        step();
        fin_ready = 1'b0;
        n_cmp++; if (fin_valid !== 1'b0) begin n_bad++; $display("FAIL dl_fin_drain got %0b exp 0", fin_valid); end
    endtask

    // Four-beat acknowledged Grant: Finish only after the fourth beat, exactly once.
    task automatic run_burst(input logic [1:0] src, input logic [1:0] dst, input logic [1:0] xact);
        finish_t exp_f;
        exp_f = make_finish(src, dst, xact);
        fin_ready = 1'b0; gnt_out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            drive(src, dst, xact, 1'b1, 1'b1);
            step();
            n_cmp++; if (fin_valid !== (b == 3)) begin n_bad++;
                $display("FAIL burst_beat%0d_fin got %0b exp %0b", b, fin_valid, (b == 3)); end
        end
        idle();
        n_cmp++; if ({fin_header_src, fin_header_dst, fin_manager_xact_id} !== exp_f) begin n_bad++;
            $display("FAIL burst_fin_fields got %0h exp %0h", {fin_header_src, fin_header_dst, fin_manager_xact_id}, exp_f); end
        fin_ready = 1'b1;
        step();
        fin_ready = 1'b0;
        n_cmp++; if (fin_valid !== 1'b0) begin n_bad++; $display("FAIL burst_single_fin got %0b exp 0", fin_valid); end
    endtask

    task automatic test_no_ack();
        fin_ready = 1'b0; gnt_out_ready = 1'b1;
        for (int b = 0; b < 6; b++) begin
            drive(2'd3, 2'd0, 2'(b), (b < 4), 1'b0);
            n_cmp++; if (gnt_in_ready !== 1'b1) begin n_bad++; $display("FAIL noack_ready%0d got %0b exp 1", b, gnt_in_ready); end
            step();
            n_cmp++; if (fin_valid !== 1'b0) begin n_bad++; $display("FAIL noack_fin%0d got %0b exp 0", b, fin_valid); end
        end
        idle();
    endtask

    task automatic test_stall();
        fin_ready = 1'b0; gnt_out_ready = 1'b1;
        drive(2'd1, 2'd0, 2'd0, 1'b0, 1'b1); step();
        drive(2'd1, 2'd0, 2'd1, 1'b0, 1'b1); step();
        drive(2'd1, 2'd0, 2'd2, 1'b0, 1'b1);
        n_cmp++; if (gnt_in_ready !== 1'b0 || gnt_out_valid !== 1'b0) begin n_bad++;
            $display("FAIL stall_full got r=%0b v=%0b exp r=0 v=0", gnt_in_ready, gnt_out_valid); end
        step();
        n_cmp++; if (gnt_in_ready !== 1'b0 || fin_manager_xact_id !== 2'd0) begin n_bad++;
            $display("FAIL stall_hold got r=%0b xact=%0d exp r=0 xact=0", gnt_in_ready, fin_manager_xact_id); end
        fin_ready = 1'b1;
        #1;
        n_cmp++; if (gnt_in_ready !== 1'b0 || gnt_out_valid !== 1'b0 || fin_valid !== 1'b1) begin n_bad++;
            $display("FAIL stall_deq_same_cycle got r=%0b v=%0b fv=%0b exp r=0 v=0 fv=1", gnt_in_ready, gnt_out_valid, fin_valid); end
        step();
        n_cmp++; if (gnt_in_ready !== 1'b1 || fin_manager_xact_id !== 2'd1) begin n_bad++;
            $display("FAIL stall_release got r=%0b xact=%0d exp r=1 xact=1", gnt_in_ready, fin_manager_xact_id); end
        step();
        idle();
        n_cmp++; if (fin_valid !== 1'b1 || fin_manager_xact_id !== 2'd2) begin n_bad++;
            $display("FAIL stall_order3 got v=%0b xact=%0d exp v=1 xact=2", fin_valid, fin_manager_xact_id); end
        step();
        fin_ready = 1'b0;
        n_cmp++; if (fin_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drain got %0b exp 0", fin_valid); end
    endtask

    task automatic test_reset_mid_burst();
        fin_ready = 1'b0; gnt_out_ready = 1'b1;
        drive(2'd0, 2'd1, 2'd3, 1'b0, 1'b1); step();
        drive(2'd2, 2'd1, 2'd0, 1'b1, 1'b1); step();
        step();
        idle();
        n_cmp++; if (fin_valid !== 1'b1) begin n_bad++; $display("FAIL mid_queued got %0b exp 1", fin_valid); end
        reset = 1'b0;
        #1;
        n_cmp++; if (fin_valid !== 1'b0 || fin_manager_xact_id !== 2'd0) begin n_bad++;
            $display("FAIL mid_rst_clear got v=%0b xact=%0d exp v=0 xact=0", fin_valid, fin_manager_xact_id); end
        step();
        reset = 1'b1;
        #1;
        run_burst(2'd3, 2'd1, 2'd2);
    endtask

    initial begin
        gnt_in_header_src = 2'd0; gnt_in_header_dst = 2'd0; gnt_in_manager_xact_id = 2'd0;
        test_reset();
        test_dataless_ack();
        run_burst(2'd0, 2'd3, 2'd1);
        test_no_ack();
        run_burst(2'd1, 2'd2, 2'd0);
        test_stall();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
